// File: rtl/native_rr_arbiter_if.sv
// Bundle of the N-master native request buses, the shared slave port and arbiter status.
// The slave modport is the arbiter's view. The master modport is the view of the environment
// (the requesting masters plus the target).
interface native_rr_arbiter_if #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int GRANT_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
);
  logic [N_MASTERS-1:0]            m_valid;
  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [N_MASTERS*STRB_WIDTH-1:0] m_wstrb;
  logic [N_MASTERS-1:0]            m_ready;
  logic [DATA_WIDTH-1:0]           m_rdata;
  logic                            s_valid;
  logic                            s_ready;
  logic [ADDR_WIDTH-1:0]           s_addr;
  logic [DATA_WIDTH-1:0]           s_wdata;
  logic [STRB_WIDTH-1:0]           s_wstrb;
  logic [DATA_WIDTH-1:0]           s_rdata;
  logic [GRANT_W-1:0]              grant;
  logic                            busy;
  logic                            timeout_err;

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, grant, busy, timeout_err
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, grant, busy, timeout_err
  );
endinterface

// File: rtl/native_rr_arbiter.sv
// Round-robin arbiter that shares one native slave among N_MASTERS native masters.
// It runs one transaction at a time and holds the grant until completion, a dropped request or a timeout.
module native_rr_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 256
) (
  input  logic               clk,
  input  logic               rst,   // asynchronous, active low
  native_rr_arbiter_if.slave bus
);
  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [GW-1:0] LAST_RST = GW'(N_MASTERS - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  last_grant_q, last_grant_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_a;
  logic [N_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_a;
  logic [N_MASTERS-1:0][STRB_WIDTH-1:0] m_wstrb_a;

  logic                  pick_vld;
  logic [GW-1:0]         pick_idx;
  logic                  done;
  logic                  tmo_fire;
  logic                  s_valid;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [STRB_WIDTH-1:0] s_wstrb;
  logic [DATA_WIDTH-1:0] m_rdata;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
    assign m_addr_a[i]    = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_wdata_a[i]   = bus.m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign m_wstrb_a[i]   = bus.m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
    assign bus.m_ready[i] = done && (grant_q == GW'(i));
  end

  // Scan downward so that the candidate closest after last_grant is the last one written.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    cand     = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = int'(last_grant_q) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      cand = GW'(idx);
      if (bus.m_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    done         = 1'b0;
    tmo_fire     = 1'b0;
    s_valid      = 1'b0;
    s_addr       = '0;
    s_wdata      = '0;
    s_wstrb      = '0;
    m_rdata      = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d   = pick_idx;
          tmo_cnt_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        s_valid = bus.m_valid[grant_q];
        s_addr  = m_addr_a[grant_q];
        s_wdata = m_wdata_a[grant_q];
        s_wstrb = m_wstrb_a[grant_q];
        if (bus.s_ready) begin
          done         = 1'b1;
          m_rdata      = bus.s_rdata;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (!bus.m_valid[grant_q]) begin
          // Master abandoned its request: no completion, rotation point unchanged.
          state_d = IDLE;
        end else if ((TIMEOUT > 0) && (tmo_cnt_q == TMO_LAST)) begin
          done         = 1'b1;
          tmo_fire     = 1'b1;
          s_valid      = 1'b0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (tmo_cnt_q != '1) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign bus.s_valid     = s_valid;
  assign bus.s_addr      = s_addr;
  assign bus.s_wdata     = s_wdata;
  assign bus.s_wstrb     = s_wstrb;
  assign bus.m_rdata     = m_rdata;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q == BUSY);
  assign bus.timeout_err = tmo_fire;
endmodule

// File: tb/tb_native_rr_arbiter.sv
// Directed bench for native_rr_arbiter: expected completions are queued when the slave response
// is driven and popped by a negedge monitor whenever m_ready fires.
module tb_native_rr_arbiter;
  localparam int N = 4, AW = 32, DW = 32, SW = 4, TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  native_rr_arbiter_if #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  native_rr_arbiter #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          idx;
    logic [DW-1:0] rdata;
    bit          tmo;
  } exp_t;

  exp_t exp_q[$];
  int total = 0, passed = 0, fails = 0;
  int lastg = N - 1;
  int served[N];
  logic [AW-1:0] req_addr [N];
  logic [DW-1:0] req_wdata[N];
  logic [SW-1:0] req_wstrb[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] mv);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (mv[c]) return c;
    end
    return 0;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_wstrb[i] = s;
    bus.m_addr[i*AW +: AW]  = a;
    bus.m_wdata[i*DW +: DW] = d;
    bus.m_wstrb[i*SW +: SW] = s;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the edge that entered BUSY; answers after lat cycles.
  task automatic serve(input int idx, input int lat, input logic [DW-1:0] rd, input bit drop);
    exp_t e;
    repeat (lat) cyc();
    e.idx = idx; e.rdata = rd; e.tmo = 1'b0;
    exp_q.push_back(e);
    bus.s_rdata = rd;
    bus.s_ready = 1'b1;
    cyc();
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;
    if (drop) bus.m_valid[idx] = 1'b0;
    lastg = idx;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.m_ready !== '0) begin
      if (exp_q.size() == 0) chk("unexpected_m_ready", 64'(bus.m_ready), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("m_ready", 64'(bus.m_ready), 64'd1 << e.idx);
        chk("m_rdata", 64'(bus.m_rdata), 64'(e.rdata));
        chk("timeout_err", 64'(bus.timeout_err), 64'(e.tmo));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   g;
    rst = 1'b1;
    bus.m_valid = '0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
    bus.s_ready = 1'b0; bus.s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      served[i] = 0;
      set_req(i, AW'(32'h1000 + i * 16), DW'(32'hA0 + i), '0);
    end
    #1 rst = 1'b0;
    bus.m_valid = 4'b0011;

    // Reset holds everything quiet even with requests pending.
    @(negedge clk);
    chk("rst_s_valid", 64'(bus.s_valid), 0);
    chk("rst_m_ready", 64'(bus.m_ready), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_grant", 64'(bus.grant), 0);
    chk("rst_timeout_err", 64'(bus.timeout_err), 0);
    chk("rst_s_addr", 64'(bus.s_addr), 0);
    chk("rst_m_rdata", 64'(bus.m_rdata), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("release_busy", 64'(bus.busy), 0);
    chk("release_s_valid", 64'(bus.s_valid), 0);
    g = rr_pick(lastg, bus.m_valid);
    cyc();
    @(negedge clk);
    chk("first_busy", 64'(bus.busy), 1);
    chk("first_grant", 64'(bus.grant), 64'(g));
    chk("first_s_valid", 64'(bus.s_valid), 1);
    chk("first_s_addr", 64'(bus.s_addr), 64'(req_addr[g]));
    serve(g, 2, 32'hA5A5_0000, 1'b1);
    bus.m_valid = '0;

    // Single read from master 1, slave latency 3.
    set_req(1, 32'h40, 32'h0, 4'h0);
    bus.m_valid = 4'b0010;
    @(negedge clk);
    chk("gap_idle_busy", 64'(bus.busy), 0);
    g = rr_pick(lastg, bus.m_valid);
    cyc();
    @(negedge clk);
    chk("rd_grant", 64'(bus.grant), 64'(g));
    chk("rd_s_valid", 64'(bus.s_valid), 1);
    chk("rd_s_addr", 64'(bus.s_addr), 64'h40);
    chk("rd_s_wstrb", 64'(bus.s_wstrb), 0);
    serve(g, 3, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    chk("rd_ready_one_cycle", 64'(bus.m_ready), 0);
    chk("rd_rdata_cleared", 64'(bus.m_rdata), 0);

    // Write from master 2 while the others are quiet.
    set_req(2, 32'h100, 32'h1234_5678, 4'b0011);
    bus.m_valid = 4'b0100;
    g = rr_pick(lastg, bus.m_valid);
    cyc();
    @(negedge clk);
    chk("wr_grant", 64'(bus.grant), 64'(g));
    chk("wr_s_valid", 64'(bus.s_valid), 1);
    chk("wr_s_addr", 64'(bus.s_addr), 64'h100);
    chk("wr_s_wdata", 64'(bus.s_wdata), 64'h1234_5678);
    chk("wr_s_wstrb", 64'(bus.s_wstrb), 64'b0011);
    serve(g, 1, 32'h0, 1'b1);

    // Fairness: every master requests continuously.
    bus.m_valid = 4'b1111;
    repeat (8) begin
      g = rr_pick(lastg, bus.m_valid);
      cyc();
      @(negedge clk);
      chk("fair_grant", 64'(bus.grant), 64'(g));
      served[g]++;
      serve(g, 2, $urandom, 1'b0);
    end
    bus.m_valid = '0;
    for (int i = 0; i < N; i++) chk("fair_count", 64'(served[i]), 2);

    // Timeout: slave never answers master 0.
    bus.m_valid = 4'b0001;
    g = rr_pick(lastg, bus.m_valid);
    cyc();
    e.idx = g; e.rdata = '0; e.tmo = 1'b1;
    exp_q.push_back(e);
    for (int c = 0; c < TMO - 1; c++) begin
      @(negedge clk);
      chk("tmo_wait_err", 64'(bus.timeout_err), 0);
      chk("tmo_wait_s_valid", 64'(bus.s_valid), 1);
      cyc();
    end
    @(negedge clk);
    chk("tmo_fire_err", 64'(bus.timeout_err), 1);
    chk("tmo_fire_s_valid", 64'(bus.s_valid), 0);
    lastg = g;
    cyc();
    bus.m_valid = '0;
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stale_m_ready", 64'(bus.m_ready), 0);
    chk("stale_busy", 64'(bus.busy), 0);
    cyc();
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;

    // Reset in the middle of a transaction.
    bus.m_valid = 4'b0010;
    g = rr_pick(lastg, bus.m_valid);
    cyc();
    @(negedge clk);
    chk("mid_busy", 64'(bus.busy), 1);
    chk("mid_grant", 64'(bus.grant), 64'(g));
    #2 rst = 1'b0;
    bus.m_valid = 4'b0011;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 0);
    chk("mid_rst_s_valid", 64'(bus.s_valid), 0);
    chk("mid_rst_grant", 64'(bus.grant), 0);
    chk("mid_rst_m_ready", 64'(bus.m_ready), 0);
    lastg = N - 1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("late_ready_m_ready", 64'(bus.m_ready), 0);
    g = rr_pick(lastg, bus.m_valid);
    cyc();
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;
    @(negedge clk);
    chk("restart_grant", 64'(bus.grant), 64'(g));
    serve(g, 1, 32'hC0DE_0000, 1'b1);
    g = rr_pick(lastg, bus.m_valid);
    cyc();
    @(negedge clk);
    chk("restart_next_grant", 64'(bus.grant), 64'(g));
    serve(g, 0, 32'hC0DE_0001, 1'b1);

    repeat (3) cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/native_rr_arbiter.md
# native_rr_arbiter

Round-robin arbiter that shares one native-interface slave (memory, peripheral, or an AXI4-Lite-to-native bridge output) among N native masters. It latches a grant, forwards the granted master's request to the slave, and returns the single-cycle ready pulse to that master. It also holds the grant until completion or a programmable timeout. It sits between the CPU/DMA-side native buses and a single native target.

## Interface
Parameters:
- N_MASTERS, 2: number of requesters (2..16)
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width
- STRB_WIDTH, DATA_WIDTH/8: write-strobe width
- TIMEOUT, 256: cycles in BUSY before forced completion; 0 disables the timeout

Ports (master buses are flat; master i occupies slice [i*W +: W]):
- clk  in  1  clock
- rst  in  1  one clock; reset is asynchronous and active-low
- m_valid  in  N_MASTERS  request valid per master; held with payload until its ready
- m_addr  in  N_MASTERS*ADDR_WIDTH  request addresses
- m_wdata  in  N_MASTERS*DATA_WIDTH  write data
- m_wstrb  in  N_MASTERS*STRB_WIDTH  write strobes; all-zero means read
- m_ready  out  N_MASTERS  one-hot completion pulse
- m_rdata  out  DATA_WIDTH  read data, broadcast to all masters, meaningful with m_ready
- s_valid  out  1  request to slave
- s_ready  in  1  slave completion pulse
- s_addr  out  ADDR_WIDTH  muxed address
- s_wdata  out  DATA_WIDTH  muxed write data
- s_wstrb  out  STRB_WIDTH  muxed strobes
- s_rdata  in  DATA_WIDTH  slave read data
- grant  out  log2(N_MASTERS)  index of current or last granted master
- busy  out  1  high in BUSY
- timeout_err  out  1  one-cycle pulse on forced completion

## Operation
- States: IDLE, BUSY. Registers: grant, last_grant, tmo_cnt.
- IDLE:
  - All m_ready=0, s_valid=0, and s_addr/s_wdata/s_wstrb=0.
  - If any m_valid is high, grant <= first requesting index searched from last_grant+1 upward, wrapping modulo N_MASTERS. Go to BUSY and clear tmo_cnt.
  - s_ready seen in IDLE (a stale response) is ignored.
- BUSY:
  - s_valid = m_valid[grant], and s_addr/s_wdata/s_wstrb = slices of the granted master (combinational).
  - s_ready=1: m_ready[grant]=1 in the same cycle and m_rdata=s_rdata. Next state is IDLE with last_grant <= grant.
  - m_valid[grant] drops without s_ready (protocol violation): return to IDLE next cycle, no m_ready, last_grant unchanged.
  - TIMEOUT>0 and tmo_cnt==TIMEOUT-1 without s_ready: m_ready[grant]=1, m_rdata=0, timeout_err=1 for that cycle, s_valid forced 0. Next state is IDLE with last_grant <= grant.
  - Otherwise tmo_cnt increments. tmo_cnt is $clog2(TIMEOUT+1) bits wide and never wraps.
- Non-granted masters see m_ready=0 and are not forwarded. Their requests wait.
- The arbiter performs one transaction at a time; there is no pipelining.

## Timing
- Reset (rst=0, async) forces IDLE, grant=0, last_grant=N_MASTERS-1 (so master 0 wins first), tmo_cnt=0, busy=0, timeout_err=0. All outputs are 0.
- Reset asserted mid-transaction: abandon immediately, no m_ready. The slave's late s_ready after release is ignored in IDLE.
- Arbitration latency: 1 cycle from m_valid in IDLE to s_valid.
- Completion: m_ready is combinational from s_ready in BUSY (zero added latency).
- Back-to-back: after a completion there is 1 IDLE cycle before the next grant. Minimum period is 2 cycles plus slave latency.
- Simultaneous requests: rotation guarantees each requester is served within N_MASTERS transactions.
- m_valid rising in the same cycle as another master's completion is arbitrated in the following IDLE cycle, using the updated last_grant.

## Test plan
- Reset: rst=0 with m_valid=2'b11 -> all outputs 0 and busy=0. After release, grant=0 and s_valid rises 1 cycle later.
- Single read: master 1 requests addr 0x40, wstrb=0; slave answers 3 cycles later with rdata 0xDEADBEEF -> m_ready=2'b10 for one cycle with m_rdata=0xDEADBEEF, then IDLE.
- Fairness: N_MASTERS=4, all masters hold requests continuously, slave ready 2 cycles after s_valid -> grant sequence 0,1,2,3,0,1…, each master served once per 4 transactions.
- Write mux: master 2 writes 0x12345678 with wstrb=4'b0011 to 0x100 while master 0 is idle -> s_addr=0x100, s_wdata=0x12345678, s_wstrb=0011 while BUSY.
- Timeout: TIMEOUT=8, slave never answers -> m_ready[grant] and timeout_err pulse exactly 8 cycles after entering BUSY, m_rdata=0. A later stale s_ready produces no m_ready.
- Mid-transaction reset: rst=0 during BUSY -> outputs 0 immediately. After release, a pending s_ready pulse is ignored and arbitration restarts from master 0.
